// File: rtl/branch_bht_predictor.sv
// Branch history table of 2-bit saturating counters with
// registered decode-stage prediction and branch/mispredict statistics.
module branch_bht_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_f,
  input  logic [31:0]      inst_f,
  input  logic             stall,
  output logic             prediction,
  output logic             prediction_q,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  ctr_t bht [ENTRIES];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  ctr_t                  wr_old;
  ctr_t                  wr_new;
  logic                  miss;

  assign rd_idx = pc_f[INDEX_BITS+1:2];
  assign wr_idx = upd_pc[INDEX_BITS+1:2];
  assign wr_old = bht[wr_idx];
  assign miss   = upd_taken ^ upd_pred;

  // Lookup sees the pre-update entry; no bypass from the write port.
  always_comb begin
    prediction = 1'b0;
    if (inst_f[6:0] == OP_BRANCH) prediction = bht[rd_idx][1];
  end

  always_comb begin
    wr_new = wr_old;
    unique case (1'b1)
      upd_taken && wr_old != ST:   wr_new = ctr_t'(wr_old + 2'd1);
      !upd_taken && wr_old != SNT: wr_new = ctr_t'(wr_old - 2'd1);
      default:                     wr_new = wr_old;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= WNT;
    end else if (upd_valid) begin
      bht[wr_idx] <= wr_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prediction_q   <= 1'b0;
      mispredict     <= 1'b0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (!stall) prediction_q <= prediction;
      mispredict <= upd_valid & miss;
      if (upd_valid && branch_cnt != '1)
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (upd_valid && miss && mispredict_cnt != '1)
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

  logic unused;
  assign unused = ^{pc_f[31:INDEX_BITS+2], pc_f[1:0],
                    upd_pc[31:INDEX_BITS+2], upd_pc[1:0],
                    inst_f[31:7]};

endmodule

// File: tb/tb_branch_bht_predictor.sv
// Directed bench for branch_bht_predictor: training, saturation,
// read-before-write, stall freeze, statistics and reset.
module tb_branch_bht_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic [31:0] inst_f;
  logic        stall;
  logic        prediction;
  logic        prediction_q;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pred;
  logic        mispredict;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] BR  = 32'h0000_0063;
  localparam logic [31:0] JAL = 32'h0000_006F;

  branch_bht_predictor dut (
    .clk(clk),
    .rst(rst),
    .pc_f(pc_f),
    .inst_f(inst_f),
    .stall(stall),
    .prediction(prediction),
    .prediction_q(prediction_q),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_pred(upd_pred),
    .mispredict(mispredict),
    .branch_cnt(branch_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pc_f = 32'h100;
    inst_f = BR;
    #1;
    checks++;
    if (prediction !== 1'b0) begin
      errors++;
      $display("FAIL reset_pred: got %0b want 0", prediction);
    end
    checks++;
    if (prediction_q !== 1'b0 || mispredict !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got q=%0b mp=%0b want 0 0",
               prediction_q, mispredict);
    end
    checks++;
    if (branch_cnt !== 16'h0 || mispredict_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %0h %0h want 0 0",
               branch_cnt, mispredict_cnt);
    end
  endtask

  task automatic test_train();
    logic exp_t [3] = '{1'b1, 1'b1, 1'b1};
    logic exp_n [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_r [2] = '{1'b0, 1'b1};
    upd_valid = 1'b1;
    upd_pc = 32'h100;
    upd_taken = 1'b1;
    upd_pred = 1'b1;
    // 01 -> 10 -> 11 -> 11
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (prediction !== exp_t[i]) begin
        errors++;
        $display("FAIL taken_%0d: got %0b want %0b", i, prediction, exp_t[i]);
      end
    end
    upd_taken = 1'b0;
    upd_pred = 1'b0;
    // 11 -> 10 -> 01 -> 00 -> 00
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (prediction !== exp_n[i]) begin
        errors++;
        $display("FAIL ntaken_%0d: got %0b want %0b", i, prediction, exp_n[i]);
      end
    end
    upd_taken = 1'b1;
    upd_pred = 1'b1;
    // 00 -> 01 -> 10 shows the floor held
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (prediction !== exp_r[i]) begin
        errors++;
        $display("FAIL recover_%0d: got %0b want %0b", i, prediction, exp_r[i]);
      end
    end
    upd_valid = 1'b0;
    tick();
    checks++;
    if (branch_cnt !== 16'd9 || mispredict_cnt !== 16'd0) begin
      errors++;
      $display("FAIL train_cnt: got %0d %0d want 9 0",
               branch_cnt, mispredict_cnt);
    end
    inst_f = JAL;
    #1;
    checks++;
    if (prediction !== 1'b0) begin
      errors++;
      $display("FAIL jal_pred: got %0b want 0", prediction);
    end
    inst_f = BR;
  endtask

  task automatic test_same_cycle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pc_f = 32'h100;
    #1;
    checks++;
    if (prediction !== 1'b0 || branch_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got pred=%0b cnt=%0d want 0 0",
               prediction, branch_cnt);
    end
    pc_f = 32'h200;
    upd_valid = 1'b1;
    upd_pc = 32'h200;
    upd_taken = 1'b1;
    upd_pred = 1'b1;
    #1;
    checks++;
    if (prediction !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_old: got %0b want 0", prediction);
    end
    tick();
    upd_valid = 1'b0;
    #1;
    checks++;
    if (prediction !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_new: got %0b want 1", prediction);
    end
    pc_f = 32'h100;
    #1;
    checks++;
    if (prediction !== 1'b1) begin
      errors++;
      $display("FAIL alias: got %0b want 1", prediction);
    end
  endtask

  task automatic test_stall();
    pc_f = 32'h104;
    stall = 1'b0;
    tick();
    checks++;
    if (prediction_q !== 1'b0) begin
      errors++;
      $display("FAIL q_load0: got %0b want 0", prediction_q);
    end
    stall = 1'b1;
    pc_f = 32'h100;
    tick();
    checks++;
    if (prediction_q !== 1'b0) begin
      errors++;
      $display("FAIL stall_1: got %0b want 0", prediction_q);
    end
    pc_f = 32'h104;
    upd_valid = 1'b1;
    upd_pc = 32'h104;
    upd_taken = 1'b1;
    upd_pred = 1'b1;
    tick();
    upd_valid = 1'b0;
    checks++;
    if (prediction_q !== 1'b0 || prediction !== 1'b1) begin
      errors++;
      $display("FAIL stall_2: got q=%0b pred=%0b want 0 1",
               prediction_q, prediction);
    end
    pc_f = 32'h100;
    tick();
    checks++;
    if (prediction_q !== 1'b0) begin
      errors++;
      $display("FAIL stall_3: got %0b want 0", prediction_q);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (prediction_q !== 1'b1) begin
      errors++;
      $display("FAIL unstall: got %0b want 1", prediction_q);
    end
    checks++;
    if (branch_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stall_cnt: got %0d want 2", branch_cnt);
    end
  endtask

  task automatic test_mispredict();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pc_f = 32'h300;
    upd_valid = 1'b1;
    upd_pc = 32'h300;
    upd_taken = 1'b1;
    upd_pred = 1'b0;
    tick();
    upd_valid = 1'b0;
    checks++;
    if (mispredict !== 1'b1 || mispredict_cnt !== 16'd1 || branch_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mp_pulse: got mp=%0b mc=%0d bc=%0d want 1 1 1",
               mispredict, mispredict_cnt, branch_cnt);
    end
    tick();
    checks++;
    if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL mp_clear: got %0b want 0", mispredict);
    end
    upd_valid = 1'b1;
    upd_pred = 1'b1;
    tick();
    upd_valid = 1'b0;
    checks++;
    if (mispredict !== 1'b0 || mispredict_cnt !== 16'd1 || branch_cnt !== 16'd2) begin
      errors++;
      $display("FAIL hit_upd: got mp=%0b mc=%0d bc=%0d want 0 1 2",
               mispredict, mispredict_cnt, branch_cnt);
    end
    // entry is now 11; reset with a pending taken update must leave 01
    rst = 1'b1;
    upd_valid = 1'b1;
    upd_pred = 1'b0;
    tick();
    rst = 1'b0;
    upd_valid = 1'b0;
    checks++;
    if (prediction !== 1'b0 || mispredict !== 1'b0 || branch_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_override: got pred=%0b mp=%0b bc=%0d want 0 0 0",
               prediction, mispredict, branch_cnt);
    end
  endtask

  task automatic test_saturate();
    upd_valid = 1'b1;
    upd_pc = 32'h300;
    upd_taken = 1'b1;
    upd_pred = 1'b0;
    for (int i = 0; i < 65535; i++) tick();
    checks++;
    if (branch_cnt !== 16'hFFFF || mispredict_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_full: got %0h %0h want ffff ffff",
               branch_cnt, mispredict_cnt);
    end
    tick();
    upd_valid = 1'b0;
    checks++;
    if (branch_cnt !== 16'hFFFF || mispredict_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_sat: got %0h %0h want ffff ffff",
               branch_cnt, mispredict_cnt);
    end
    checks++;
    if (prediction !== 1'b1 || mispredict !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst: got pred=%0b mp=%0b want 1 1",
               prediction, mispredict);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (branch_cnt !== 16'h0 || mispredict_cnt !== 16'h0 ||
        mispredict !== 1'b0 || prediction !== 1'b0) begin
      errors++;
      $display("FAIL final_rst: got bc=%0h mc=%0h mp=%0b pred=%0b want 0 0 0 0",
               branch_cnt, mispredict_cnt, mispredict, prediction);
    end
  endtask

  initial begin
    rst = 1'b1;
    pc_f = '0;
    inst_f = '0;
    stall = 1'b0;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_pred = 1'b0;
    test_reset();
    test_train();
    test_same_cycle();
    test_stall();
    test_mispredict();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
